// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_sequencer_pkg : shared opcodes, FSM states and helpers         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package muldiv_sequencer_pkg;

  localparam int MD_ITER = 32;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'b00,
    MD_ST_RUN  = 2'b01,
    MD_ST_FIX  = 2'b10
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic op_is_unsigned_mult(input logic [1:0] op);
    return op == MD_OP_MULTU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_step : one radix-2 shift-add (mult) or restoring (div) step    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                is_div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     operand_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // acc = {partial high word, multiplier / dividend bits still to consume}
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : {(XLEN+1){1'b0}});
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, operand_i};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_sequencer : iterative MULT/MULTU/DIV/DIVU sequencer owning    |
// | HI/LO; MULDIV_FAST_MULT_EN selects a single-cycle multiply. Rev 1.0  |
// +----------------------------------------------------------------------+
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = MD_ITER
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StartE,
  input  logic [1:0]      OpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            MfReqD,
  input  logic            MdStartD,
  output logic            Busy,
  output logic            MdStallD,
  output logic [XLEN-1:0] HiOut,
  output logic [XLEN-1:0] LoOut
);

  localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              res_neg_q, res_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              div_zero;

  assign sgn_a = op_is_signed(OpE) & SrcAE[XLEN-1];
  assign sgn_b = op_is_signed(OpE) & SrcBE[XLEN-1];
  assign abs_a = sgn_a ? -SrcAE : SrcAE;
  assign abs_b = sgn_b ? -SrcBE : SrcBE;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i  (is_div_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc)
  );

  // A zero divisor leaves quotient all-ones and remainder |A|; the sign
  // fixup on the remainder then restores the raw dividend.
  assign div_zero = (opnd_q == '0);
  assign prod_fix = res_neg_q ? -acc_q : acc_q;
  assign quo_fix  = div_zero ? '1 : (res_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign rem_fix  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      MD_ST_IDLE: begin
        if (StartE) begin
          is_div_d  = op_is_div(OpE);
          res_neg_d = sgn_a ^ sgn_b;
          rem_neg_d = sgn_a;
          cnt_d     = '0;
          state_d   = MD_ST_RUN;
          if (op_is_div(OpE)) begin
            opnd_d = abs_b;
            acc_d  = {{XLEN{1'b0}}, abs_a};
          end else begin
            opnd_d = abs_a;
            acc_d  = {{XLEN{1'b0}}, abs_b};
          end
`ifdef MULDIV_FAST_MULT_EN
          if (!op_is_div(OpE)) begin
            acc_d   = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
            state_d = MD_ST_FIX;
          end
`endif
        end
      end
      MD_ST_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = MD_ST_FIX;
        end
      end
      MD_ST_FIX: begin
        state_d = MD_ST_IDLE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
      end
      default: state_d = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy     = (state_q != MD_ST_IDLE);
  assign MdStallD = (Busy | StartE) & (MfReqD | MdStartD);
  assign HiOut    = hi_q;
  assign LoOut    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_sequencer : scoreboard bench for muldiv_sequencer          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_muldiv_sequencer;

  localparam int BUSY_CYCLES = 33;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StartE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE, SrcBE;
  logic        MfReqD, MdStartD;
  logic        Busy, MdStallD;
  logic [31:0] HiOut, LoOut;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [31:0] last_hi, last_lo;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StartE   (StartE),
    .OpE      (OpE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .MfReqD   (MfReqD),
    .MdStartD (MdStartD),
    .Busy     (Busy),
    .MdStallD (MdStallD),
    .HiOut    (HiOut),
    .LoOut    (LoOut)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] p;
    longint      qa, qb;
    qa = longint'($signed(a));
    qb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(qa * qb); r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.hi = 32'd0; r.lo = 32'h8000_0000; end
        else begin r.lo = 32'(qa / qb); r.hi = 32'(qa % qb); end
      end
      default: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
    endcase
    return r;
  endfunction

  // Issues one operation, checks stall/busy timing each cycle and the
  // final HI/LO against the scoreboard entry pushed at issue time.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mf, input logic md, input bit spurious);
    exp_t e;
    int   cyc;
    logic stall_exp;
    stall_exp = mf | md;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; MfReqD = mf; MdStartD = md;
    #1;
    n_cmp++; if (MdStallD !== stall_exp) begin n_err++; $display("FAIL stall_start: got %b want %b", MdStallD, stall_exp); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL busy_start: got %b want 0", Busy); end
    @(negedge clk);
    StartE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;
    #1;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 200) begin
      cyc++;
      n_cmp++; if (MdStallD !== stall_exp) begin n_err++; $display("FAIL stall_busy cyc %0d: got %b want %b", cyc, MdStallD, stall_exp); end
      if (cyc == 1) begin
        n_cmp++; if (HiOut !== last_hi) begin n_err++; $display("FAIL hi_hold: got %h want %h", HiOut, last_hi); end
        n_cmp++; if (LoOut !== last_lo) begin n_err++; $display("FAIL lo_hold: got %h want %h", LoOut, last_lo); end
      end
      @(negedge clk);
      StartE = (spurious && (cyc == 5));
      if (StartE) begin OpE = ~op; SrcAE = 32'd12345; SrcBE = 32'd7; end
      #1;
    end
    StartE = 1'b0;
    n_cmp++; if (cyc != BUSY_CYCLES) begin n_err++; $display("FAIL busy_len op %b: got %0d want %0d", op, cyc, BUSY_CYCLES); end
    n_cmp++; if (MdStallD !== 1'b0) begin n_err++; $display("FAIL stall_done: got %b want 0", MdStallD); end
    if (sb.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      n_cmp++; if (HiOut !== e.hi) begin n_err++; $display("FAIL hi op %b a %h b %h: got %h want %h", op, a, b, HiOut, e.hi); end
      n_cmp++; if (LoOut !== e.lo) begin n_err++; $display("FAIL lo op %b a %h b %h: got %h want %h", op, a, b, LoOut, e.lo); end
      last_hi = e.hi;
      last_lo = e.lo;
    end
    MfReqD = 1'b0; MdStartD = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; StartE = 1'b0; OpE = 2'b00; SrcAE = '0; SrcBE = '0; MfReqD = 1'b1; MdStartD = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (HiOut !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", HiOut); end
    n_cmp++; if (LoOut !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", LoOut); end
    n_cmp++; if (MdStallD !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", MdStallD); end
    @(negedge clk);
    rst_n = 1'b1; MfReqD = 1'b0;
    last_hi = '0; last_lo = '0;
  endtask

  task automatic test_mult();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div_boundaries();
    run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    StartE = 1'b1; OpE = 2'b11; SrcAE = 32'd1000; SrcBE = 32'd3;
    @(negedge clk);
    StartE = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL abort_pre_busy: got %b want 1", Busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", Busy); end
    n_cmp++; if (HiOut !== 32'd0) begin n_err++; $display("FAIL abort_hi: got %h want 0", HiOut); end
    n_cmp++; if (LoOut !== 32'd0) begin n_err++; $display("FAIL abort_lo: got %h want 0", LoOut); end
    @(negedge clk);
    rst_n = 1'b1;
    last_hi = '0; last_lo = '0;
    run_op(2'b11, 32'd9, 32'd4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 1'b1, 1'b1);
    run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    run_op(2'b00, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_boundaries();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
